// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: drain FSM encoding and FIFO sizing.
package uart_pkg;

    localparam int FIFO_DEPTH = 16;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_ACCEPT = 2'd2;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte push channel into the UART transmit FIFO.
interface uart_tx_fifo_if;

    // A byte transfers on a clock edge where push_valid && push_ready; push_data is
    // only meaningful while push_valid is high, and ready never depends on valid.
    logic [7:0] push_data;
    logic       push_valid;
    logic       push_ready;

    modport master (output push_data, output push_valid, input push_ready);
    modport slave  (input push_data, input push_valid, output push_ready);

endinterface

// File: rtl/uart_byte_ram.sv
// DEPTH x 8 register array: one synchronous write port, one asynchronous read port.
module uart_byte_ram #(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [7:0]            wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [7:0]            rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter; drains one byte per transmitter-idle period
// using a one-cycle trigger pulse.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH      = FIFO_DEPTH,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    uart_tx_fifo_if.slave         push,
    input  logic                  flush,
    output logic [7:0]            tx_byte,
    output logic                  tx_trigger,
    input  logic                  tx_ready,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic [1:0]            drain_state
);

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count_q;
    logic [1:0]            state;
    logic [7:0]            rd_data;
    logic                  empty;
    logic                  full;
    logic                  push_fire;
    logic                  pop_fire;

    // Full/empty come from the registered count, so a pop in the same cycle
    // never makes room for a push.
    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_COUNT);
    assign push_fire = push.push_valid && !full && !flush;
    assign pop_fire  = (state == S_IDLE) && !empty && tx_ready && !flush;

    assign push.push_ready = !full;
    assign count           = count_q;
    assign drain_state     = state;

    uart_byte_ram #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clock   (clock),
        .wr_en   (push_fire),
        .wr_addr (wr_ptr),
        .wr_data (push.push_data),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_fire) wr_ptr <= wr_ptr + 1'b1;
            if (pop_fire)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_fire, pop_fire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky: a dropped byte stays visible until reset, regardless of flush.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (push.push_valid && full) begin
            overflow <= 1'b1;
        end
    end

    // ACCEPT holds off the next launch until the transmitter has visibly gone busy,
    // since its ready status lags the trigger it sampled.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            tx_byte    <= 8'h00;
            tx_trigger <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop_fire) begin
                        tx_byte    <= rd_data;
                        tx_trigger <= 1'b1;
                        state      <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    tx_trigger <= 1'b0;
                    state      <= S_ACCEPT;
                end
                S_ACCEPT: begin
                    if (!tx_ready) state <= S_IDLE;
                end
                default: begin
                    tx_trigger <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a behavioural transmitter, a queue model checked every cycle,
// and directed scenarios with hand-computed expectations.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int CPB   = 4;

    // ---------------- clock / reset / DUT ----------------
    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          tx_ready;
    logic [7:0]    tx_byte;
    logic          tx_trigger;
    logic [AW:0]   count;
    logic          overflow;
    logic [1:0]    drain_state;

    uart_tx_fifo_if push_if ();

    uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clock       (clock),
        .reset       (reset),
        .push        (push_if.slave),
        .flush       (flush),
        .tx_byte     (tx_byte),
        .tx_trigger  (tx_trigger),
        .tx_ready    (tx_ready),
        .count       (count),
        .overflow    (overflow),
        .drain_state (drain_state)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_ok(input string name, input bit ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: actual 0 required 1 at %0t", name, $time);
        end
    endtask

    // ---------------- behavioural transmitter ----------------
    // tx_mode: 0 = transmitter model, 1 = ready held low, 2 = ready held high
    int         tx_mode = 0;
    logic       tx_busy = 1'b0;
    logic       tx_line = 1'b1;
    logic [9:0] tx_frame;
    int         tx_delay = 0;
    int         tx_bit, tx_cyc;
    logic       line_q[$];

    always @(negedge clock) begin
        if (reset) begin
            tx_busy  = 1'b0;
            tx_line  = 1'b1;
            tx_delay = 0;
        end else if (tx_delay > 0) begin
            tx_delay--;
            if (tx_delay == 0) begin
                tx_busy = 1'b1;
                tx_bit  = 0;
                tx_cyc  = 0;
                tx_line = tx_frame[0];
                line_q.push_back(tx_line);
            end
        end else if (tx_busy) begin
            tx_cyc++;
            if (tx_cyc == CPB) begin
                tx_cyc = 0;
                tx_bit++;
                if (tx_bit == 10) begin
                    tx_busy = 1'b0;
                    tx_line = 1'b1;
                end else begin
                    tx_line = tx_frame[tx_bit];
                    line_q.push_back(tx_line);
                end
            end
        end else if (tx_mode == 0 && tx_trigger) begin
            tx_frame = {1'b1, tx_byte, 1'b0};
            tx_delay = 2;
        end
    end

    assign tx_ready = (tx_mode == 0) ? !tx_busy : (tx_mode == 2);

    // ---------------- model + per-cycle compare ----------------
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic       m_ovf  = 1'b0;
    logic [7:0] m_byte = 8'h00;
    int         gap = 100;
    int         trig_count = 0;
    logic       e_seen = 1'b0;
    logic       e_reset, e_valid, e_flush, e_txr;
    logic [7:0] e_data;

    always @(posedge clock) begin
        e_seen  = 1'b1;
        e_reset = reset;
        e_valid = push_if.push_valid;
        e_data  = push_if.push_data;
        e_flush = flush;
        e_txr   = tx_ready;
    end

    always @(negedge clock) begin
        int pre;
        if (e_seen) begin
            pre = exp_q.size();
            gap++;
            if (e_reset) begin
                exp_q.delete();
                m_ovf  = 1'b0;
                m_byte = 8'h00;
                gap    = 100;
                check_eq("trigger_during_reset", int'(tx_trigger), 0);
            end else begin
                if (tx_trigger) begin
                    trig_count++;
                    got_q.push_back(tx_byte);
                    check_ok("launch_needs_data_ready_noflush", pre > 0 && e_txr && !e_flush);
                    check_ok("trigger_spacing", gap >= 3);
                    gap = 0;
                    if (pre > 0) m_byte = exp_q.pop_front();
                end
                if (e_valid && pre == DEPTH) m_ovf = 1'b1;
                if (e_flush) exp_q.delete();
                else if (e_valid && pre < DEPTH) exp_q.push_back(e_data);
            end
            check_eq("count", int'(count), exp_q.size());
            check_eq("push_ready", int'(push_if.push_ready), int'(exp_q.size() < DEPTH));
            check_eq("overflow", int'(overflow), int'(m_ovf));
            check_eq("tx_byte", int'(tx_byte), int'(m_byte));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d);
        push_if.push_valid = 1'b1;
        push_if.push_data  = d;
        tick();
        push_if.push_valid = 1'b0;
    endtask

    task automatic do_reset();
        push_if.push_valid = 1'b0;
        flush = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        got_q.delete();
        line_q.delete();
    endtask

    task automatic wait_trigs(input int target, input int budget, input string name);
        int k = 0;
        while (trig_count < target && k < budget) begin
            tick();
            k++;
        end
        check_ok(name, trig_count >= target);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        logic       exp_line[10];
        logic [7:0] exp_seq[$];
        int         t0, k;

        exp_line = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        push_if.push_valid = 1'b0;
        push_if.push_data  = 8'h00;

        reset = 1'b1;
        tick(); tick(); tick();
        check_eq("reset_count", int'(count), 0);
        check_eq("reset_push_ready", int'(push_if.push_ready), 1);
        check_eq("reset_overflow", int'(overflow), 0);
        check_eq("reset_trigger", int'(tx_trigger), 0);
        check_eq("reset_tx_byte", int'(tx_byte), 0);
        check_eq("reset_state", int'(drain_state), int'(S_IDLE));
        reset = 1'b0;
        tick();

        // Single byte: latency, data and serial frame
        line_q.delete();
        push_byte(8'hA5);
        check_eq("t1_count_after_push", int'(count), 1);
        check_eq("t1_no_early_trigger", int'(tx_trigger), 0);
        tick();
        check_eq("t1_trigger_latency", int'(tx_trigger), 1);
        check_eq("t1_tx_byte", int'(tx_byte), 8'hA5);
        check_eq("t1_count_after_pop", int'(count), 0);
        tick();
        check_eq("t1_trigger_width", int'(tx_trigger), 0);
        k = 0;
        while (line_q.size() < 10 && k < 200) begin tick(); k++; end
        check_ok("t1_frame_complete", line_q.size() >= 10);
        for (int i = 0; i < 10; i++) begin
            if (i < line_q.size()) check_eq($sformatf("t1_line_bit%0d", i), int'(line_q[i]), int'(exp_line[i]));
        end
        repeat (CPB + 2) tick();
        check_eq("t1_line_idle_high", int'(tx_line), 1);
        check_eq("t1_tx_byte_held", int'(tx_byte), 8'hA5);

        // Burst fill with transmitter held busy, overflow, then in-order drain
        do_reset();
        tx_mode = 1;
        for (int i = 0; i < 16; i++) begin
            push_if.push_valid = 1'b1;
            push_if.push_data  = i[7:0];
            tick();
        end
        push_if.push_valid = 1'b0;
        check_eq("t2_count_full", int'(count), 16);
        check_eq("t2_push_ready_low", int'(push_if.push_ready), 0);
        check_eq("t2_no_overflow_yet", int'(overflow), 0);
        push_byte(8'h77);
        check_eq("t2_overflow_set", int'(overflow), 1);
        check_eq("t2_count_stays", int'(count), 16);
        got_q.delete();
        t0 = trig_count;
        tx_mode = 0;
        wait_trigs(t0 + 16, 1500, "t2_drain_timeout");
        check_eq("t2_drained_n", got_q.size(), 16);
        for (int i = 0; i < 16; i++) begin
            if (i < got_q.size()) check_eq($sformatf("t2_order%0d", i), int'(got_q[i]), i);
        end
        check_eq("t2_count_empty", int'(count), 0);
        check_eq("t2_overflow_sticky", int'(overflow), 1);

        // Transmitter that never drops ready: one trigger, FSM parked in ACCEPT
        do_reset();
        tx_mode = 2;
        t0 = trig_count;
        push_byte(8'h11);
        push_byte(8'h22);
        repeat (20) tick();
        check_eq("t3_one_trigger", trig_count - t0, 1);
        check_eq("t3_state_accept", int'(drain_state), int'(S_ACCEPT));
        check_eq("t3_count_once", int'(count), 1);

        // Flush while the first byte is launching
        do_reset();
        tx_mode = 0;
        t0 = trig_count;
        push_if.push_valid = 1'b1;
        push_if.push_data  = 8'h31;
        tick();
        push_if.push_data  = 8'h32;
        tick();
        check_eq("t4_launch_seen", int'(tx_trigger), 1);
        push_if.push_data  = 8'h33;
        flush = 1'b1;
        tick();
        push_if.push_valid = 1'b0;
        flush = 1'b0;
        check_eq("t4_count_flushed", int'(count), 0);
        repeat (100) tick();
        check_eq("t4_single_trigger", trig_count - t0, 1);
        check_eq("t4_sent_byte", (got_q.size() > 0) ? int'(got_q[0]) : -1, 8'h31);
        check_eq("t4_count_still_zero", int'(count), 0);

        // Full FIFO: push colliding with pop is rejected; then pointer wrap
        do_reset();
        tx_mode = 1;
        for (int i = 0; i < 16; i++) begin
            push_if.push_valid = 1'b1;
            push_if.push_data  = 8'h40 + i[7:0];
            tick();
        end
        push_if.push_valid = 1'b0;
        check_eq("t5_count_full", int'(count), 16);
        got_q.delete();
        t0 = trig_count;
        push_if.push_valid = 1'b1;
        push_if.push_data  = 8'h99;
        tx_mode = 0;
        tick();
        push_if.push_valid = 1'b0;
        check_eq("t5_pop_trigger", int'(tx_trigger), 1);
        check_eq("t5_count_after_collision", int'(count), 15);
        check_eq("t5_overflow", int'(overflow), 1);
        check_eq("t5_push_ready_back", int'(push_if.push_ready), 1);
        for (int i = 0; i < 40; i++) begin
            push_byte(8'h80 + i[7:0]);
            wait_trigs(t0 + 2 + i, 200, "t5_pair_timeout");
        end
        wait_trigs(t0 + 56, 1500, "t5_drain_timeout");
        exp_seq.delete();
        for (int i = 0; i < 16; i++) exp_seq.push_back(8'h40 + i[7:0]);
        for (int i = 0; i < 40; i++) exp_seq.push_back(8'h80 + i[7:0]);
        check_eq("t5_sent_n", got_q.size(), 56);
        for (int i = 0; i < 56; i++) begin
            if (i < got_q.size()) check_eq($sformatf("t5_order%0d", i), int'(got_q[i]), int'(exp_seq[i]));
        end
        check_eq("t5_count_empty", int'(count), 0);
        repeat (60) tick();

        // Reset mid-transmission with five bytes queued
        for (int i = 0; i < 6; i++) begin
            push_if.push_valid = 1'b1;
            push_if.push_data  = 8'h61 + i[7:0];
            tick();
        end
        push_if.push_valid = 1'b0;
        check_eq("t6_count_five", int'(count), 5);
        check_eq("t6_overflow_before", int'(overflow), 1);
        tick(); tick();
        reset = 1'b1;
        tick();
        check_eq("t6_count_reset", int'(count), 0);
        check_eq("t6_trigger_reset", int'(tx_trigger), 0);
        check_eq("t6_overflow_reset", int'(overflow), 0);
        check_eq("t6_push_ready_reset", int'(push_if.push_ready), 1);
        check_eq("t6_state_reset", int'(drain_state), int'(S_IDLE));
        reset = 1'b0;
        t0 = trig_count;
        repeat (60) tick();
        check_eq("t6_no_trigger_after", trig_count - t0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte FIFO that sits directly upstream of the UART transmitter and decouples bursty producers (CPU port writes, debug dumps) from the serial line rate. It accepts bytes with a valid/ready push handshake, stores up to DEPTH of them, and drains them one at a time into the transmitter. The drain side uses the transmitter's single-cycle write trigger and its level-sensitive "ready to transmit" status, so back-to-back bytes go out with no idle bit-time between them.

## Interface
- DEPTH, 16: storage entries; power of two, 2..256
- ADDR_WIDTH, 4: log2(DEPTH)
- clock  in  1  system clock, shared with the transmitter
- reset  in  1  synchronous, active-high
- push_data  in  8  byte to enqueue
- push_valid  in  1  enqueue request; accepted on a clock edge where push_valid && push_ready
- push_ready  out  1  high when not full
- flush  in  1  synchronous; empties storage, does not abort an in-flight launch
- tx_byte  out  8  byte presented to the transmitter; held stable from trigger until the next launch
- tx_trigger  out  1  one-cycle pulse that starts a transmission
- tx_ready  in  1  transmitter idle status
- count  out  ADDR_WIDTH+1  number of stored bytes, 0..DEPTH
- overflow  out  1  sticky; set by a push attempt while full; cleared only by reset

## Operation
- Storage: circular buffer with wr_ptr and rd_ptr of ADDR_WIDTH bits, wrapping modulo DEPTH. Full/empty are derived only from count: empty = (count==0), full = (count==DEPTH).
- Push: on an accepted push, mem[wr_ptr] <= push_data and wr_ptr increments. A push while full drops the byte, sets overflow, and leaves count unchanged.
- Pop: occurs only in the LAUNCH transition. tx_byte <= mem[rd_ptr] and rd_ptr increments.
- count: +1 on push only, -1 on pop only, unchanged when push and pop happen together. Pop is gated by registered !empty and push by registered !full, so count never underflows or overflows.
- Drain FSM:
  - IDLE: if !empty && tx_ready && !flush, pop, set tx_trigger=1, go to LAUNCH.
  - LAUNCH: tx_trigger=0, go to ACCEPT.
  - ACCEPT: wait for tx_ready==0, then go to IDLE.
  - The ACCEPT state exists because the transmitter's ready status falls only one cycle after it samples the trigger. Without it, a second trigger would fire into a still-idle-looking transmitter.
- flush: clears wr_ptr, rd_ptr and count in the same cycle. An accepted push in that same cycle is discarded. The FSM state, tx_byte and overflow are unaffected. While flush is high, IDLE does not launch.
- Reset values: state IDLE, pointers 0, count 0, tx_byte 8'h00, tx_trigger 0, overflow 0, push_ready 1. Mid-operation reset discards everything; the transmitter shares the same reset.

## Timing
- Push at edge E: count and push_ready reflect the push after E. If the FIFO was empty with tx_ready high, tx_trigger is high during the cycle after edge E+1, so latency is 1 cycle from push acceptance to trigger.
- tx_trigger is high for exactly 1 cycle; two triggers are at least 3 cycles apart.
- Next launch follows 1 cycle after tx_ready rises again, i.e. the stop-bit end.
- push_ready goes low the cycle after the DEPTH-th push and returns the cycle after the next pop.
- Push into a full FIFO in the same cycle as a pop is rejected, because push_ready is registered from the pre-pop count.

## Structure
- Shared package uart_pkg holds the drain state encoding (IDLE/LAUNCH/ACCEPT) and the DEPTH default.
- Natural sub-module: uart_byte_ram, a DEPTH×8 single-write, asynchronous-read register array. The pointers, count and FSM live in uart_tx_fifo.

## Test plan
- Push 8'hA5 into an empty FIFO with a transmitter of CLOCKS_PER_BIT=4 attached -> tx_trigger 1 cycle after acceptance, tx_byte=8'hA5, count returns to 0, line shows 0,1,0,1,0,0,1,0,1 then 1.
- Burst-push 8'h00..8'h0F (16 bytes) with tx_ready held low -> count=16, push_ready=0; a 17th push sets overflow=1 and count stays 16. Release tx_ready -> bytes emerge in order 00..0F.
- With tx_ready held high (transmitter never drops it) -> exactly one trigger, FSM remains in ACCEPT, count decremented once only.
- Push 3 bytes, assert flush while the first is launching -> the first byte is transmitted, count=0, no further triggers.
- Fill to 16, then push while a pop occurs in the same cycle -> push rejected, overflow=1, count=15. Pointer wrap verified by 40 further push/pop pairs with incrementing data.
- Assert reset mid-transmission with count=5 -> the next cycle shows count=0, tx_trigger=0, overflow=0, push_ready=1, and no trigger afterwards.
